// File: rtl/fw_upload_responder_if.sv
// Byte-stream, SRAM write and CPU-control signals of the firmware upload responder.
// master = host/UART/arbiter side, slave = the responder itself.
interface fw_upload_responder_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic        cpu_rst;
  logic        loaded_ok;
  logic        busy;

  modport master (
    output rx_data, rx_valid, tx_ready, mem_ready,
    input  tx_data, tx_valid, mem_addr, mem_wdata, mem_we, cpu_rst, loaded_ok, busy
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready, mem_ready,
    output tx_data, tx_valid, mem_addr, mem_wdata, mem_we, cpu_rst, loaded_ok, busy
  );
endinterface

// File: rtl/fw_upload_responder.sv
// UART firmware upload responder: 'R' size payload crc framing, 16-bit SRAM packing,
// CRC32 check with ACK/NAK, CPU reset release on 'r'. Optional inter-byte timeout: FW_TIMEOUT_EN.
module fw_upload_responder #(
  parameter int unsigned MAX_SIZE       = 524288,
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input logic                  clk,
  input logic                  rst,
  fw_upload_responder_if.slave bus
);
  localparam logic [7:0] CmdLoad = 8'h52;
  localparam logic [7:0] CmdRun  = 8'h72;
  localparam logic [7:0] RspAck  = 8'h06;
  localparam logic [7:0] RspNak  = 8'h15;

  typedef enum logic [2:0] {StIdle, StSize, StData, StCrc, StCheck, StResp} state_e;

  state_e      state_q;
  logic [31:0] cnt_q, size_q, crc_q, rx_crc_q;
  logic [7:0]  low_q;
  logic        overrun_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic [17:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic        mem_we_q;
  logic        cpu_rst_q;
  logic        loaded_ok_q;

  logic [31:0] size_shift;
  logic        wr_pending;
  logic        wr_clear;
  logic        last_data;

  assign size_shift = {bus.rx_data, size_q[31:8]};
  assign wr_pending = mem_we_q && !bus.mem_ready;
  assign wr_clear   = !wr_pending;
  assign last_data  = (cnt_q + 32'd1) == size_q;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

`ifdef FW_TIMEOUT_EN
  logic [31:0] idle_q;
`else
  // Timeout parameter only matters when the timeout feature is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      size_q      <= '0;
      crc_q       <= '0;
      rx_crc_q    <= '0;
      low_q       <= '0;
      overrun_q   <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cpu_rst_q   <= 1'b1;
      loaded_ok_q <= 1'b0;
`ifdef FW_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      if (mem_we_q && bus.mem_ready) mem_we_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == CmdLoad) begin
              cnt_q       <= '0;
              size_q      <= '0;
              crc_q       <= 32'hFFFF_FFFF;
              overrun_q   <= 1'b0;
              cpu_rst_q   <= 1'b1;
              loaded_ok_q <= 1'b0;
              state_q     <= StSize;
            end else if (bus.rx_data == CmdRun) begin
              if (loaded_ok_q) begin
                cpu_rst_q <= 1'b0;
              end else begin
                tx_data_q  <= RspNak;
                tx_valid_q <= 1'b1;
                state_q    <= StResp;
              end
            end
          end
        end

        StSize: begin
          if (bus.rx_valid) begin
            size_q <= size_shift;
            if (cnt_q == 32'd3) begin
              cnt_q <= '0;
              if (size_shift == 32'd0 || size_shift > 32'(MAX_SIZE)) begin
                tx_data_q  <= RspNak;
                tx_valid_q <= 1'b1;
                state_q    <= StResp;
              end else begin
                state_q <= StData;
              end
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
        end

        StData: begin
          if (bus.rx_valid) begin
            cnt_q <= cnt_q + 32'd1;
            // A byte arriving while a write is still pending is lost; the count still advances.
            if (wr_pending) begin
              overrun_q <= 1'b1;
            end else begin
              crc_q <= crc_byte(crc_q, bus.rx_data);
              if (cnt_q[0]) begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= cnt_q[18:1];
                mem_wdata_q <= {bus.rx_data, low_q};
              end else if (last_data) begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= cnt_q[18:1];
                mem_wdata_q <= {8'h00, bus.rx_data};
              end else begin
                low_q <= bus.rx_data;
              end
            end
            if (last_data) begin
              cnt_q   <= '0;
              state_q <= StCrc;
            end
          end
        end

        StCrc: begin
          // cnt_q == 4 means all CRC bytes are in and the final write is still draining.
          if (cnt_q == 32'd4) begin
            if (wr_clear) state_q <= StCheck;
          end else if (bus.rx_valid) begin
            rx_crc_q <= {bus.rx_data, rx_crc_q[31:8]};
            cnt_q    <= cnt_q + 32'd1;
            if (cnt_q == 32'd3 && wr_clear) state_q <= StCheck;
          end
        end

        StCheck: begin
          if (~crc_q == rx_crc_q && !overrun_q) begin
            tx_data_q   <= RspAck;
            loaded_ok_q <= 1'b1;
          end else begin
            tx_data_q <= RspNak;
          end
          tx_valid_q <= 1'b1;
          state_q    <= StResp;
        end

        StResp: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase

`ifdef FW_TIMEOUT_EN
      if ((state_q == StSize || state_q == StData || state_q == StCrc) && !bus.rx_valid) begin
        if (idle_q + 32'd1 >= 32'(TIMEOUT_CYCLES)) begin
          idle_q      <= '0;
          tx_data_q   <= RspNak;
          tx_valid_q  <= 1'b1;
          loaded_ok_q <= 1'b0;
          state_q     <= StResp;
        end else begin
          idle_q <= idle_q + 32'd1;
        end
      end else begin
        idle_q <= '0;
      end
`endif
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.loaded_ok = loaded_ok_q;
  assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_fw_upload_responder.sv
// Randomized bench for fw_upload_responder: frames built from a byte-queue model, responses,
// SRAM contents and cpu_rst compared against a table-driven CRC32 reference.
module tb_fw_upload_responder;
  localparam int unsigned MaxSize = 524288;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fw_upload_responder_if bus ();

  fw_upload_responder #(
    .MAX_SIZE      (MaxSize),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0]  crc_tab [256];
  logic [7:0]   pay [$];
  logic [7:0]   txq [$];
  logic [15:0]  wmem [int];
  int           wcount;
  bit           mem_hold;
  int           mem_wait;
  int           tx_wait;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (pay[i]) c = crc_tab[(c[7:0] ^ pay[i])] ^ (c >> 8);
    return ~c;
  endfunction

  // Arbiter and UART TX models: random ready with a bounded wait, recording each transfer.
  initial begin
    bus.mem_ready = 1'b0;
    bus.tx_ready  = 1'b0;
    mem_wait = 0;
    tx_wait  = 0;
    wcount   = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_we && !mem_hold && (mem_wait >= 3 || $urandom_range(0, 1) == 1)) begin
        bus.mem_ready = 1'b1;
        wmem[int'(bus.mem_addr)] = bus.mem_wdata;
        wcount++;
        mem_wait = 0;
      end else begin
        bus.mem_ready = 1'b0;
        if (bus.mem_we && !mem_hold) mem_wait++;
      end
      if (bus.tx_valid && (tx_wait >= 3 || $urandom_range(0, 1) == 1)) begin
        bus.tx_ready = 1'b1;
        txq.push_back(bus.tx_data);
        tx_wait = 0;
      end else begin
        bus.tx_ready = 1'b0;
        if (bus.tx_valid) tx_wait++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (txq.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_txcnt"}, txq.size(), 1);
    if (txq.size() > 0) check({tag, "_txbyte"}, txq.pop_front(), exp);
    repeat (3) @(negedge clk);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic send_size(input logic [31:0] s);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = s[8*i +: 8];
      send_byte(b, 6);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_txv"},  bus.tx_valid, 0);
    check({tag, "_txd"},  bus.tx_data, 0);
    check({tag, "_we"},   bus.mem_we, 0);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_wd"},   bus.mem_wdata, 0);
    check({tag, "_crst"}, bus.cpu_rst, 1);
    check({tag, "_ok"},   bus.loaded_ok, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  // Full upload of pay[] with the given trailer CRC; hold forces an overrun mid-payload.
  task automatic run_upload(input string tag, input logic [31:0] crc_val, input bit hold);
    int  n;
    bit  ack;
    n   = pay.size();
    ack = !hold && (crc_val == ref_crc());
    check({tag, "_stray"}, txq.size(), 0);
    wmem.delete();
    wcount = 0;
    send_byte(8'h52, 0);
    check({tag, "_crst_up"}, bus.cpu_rst, 1);
    check({tag, "_ok_clr"}, bus.loaded_ok, 0);
    repeat (6) @(negedge clk);
    send_size(32'(n));
    for (int i = 0; i < n; i++) begin
      if (hold && i == 1) mem_hold = 1'b1;
      send_byte(pay[i], 6);
    end
    mem_hold = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) send_byte(crc_val[8*i +: 8], 6);
    bus.rx_data  = crc_val[31:24];
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check({tag, "_lat_check"}, bus.tx_valid, 0);
    @(negedge clk);
    check({tag, "_lat_resp"}, bus.tx_valid, 1);
    wait_tx(tag, ack ? 8'h06 : 8'h15);
    check({tag, "_ok"}, bus.loaded_ok, ack);
    check({tag, "_crst"}, bus.cpu_rst, 1);
    if (!hold) begin
      check({tag, "_wcount"}, wcount, (n + 1) / 2);
      for (int w = 0; w < (n + 1) / 2; w++) begin
        logic [15:0] e;
        e = {(2 * w + 1 < n) ? pay[2 * w + 1] : 8'h00, pay[2 * w]};
        check($sformatf("%s_word%0d", tag, w), wmem.exists(w) ? wmem[w] : 16'hxxxx, e);
      end
    end
  endtask

  // 'r' after an upload: releases the CPU only after an ACK, otherwise NAKs.
  task automatic run_release(input string tag, input bit ack);
    send_byte(8'h72, 0);
    check({tag, "_crst_r"}, bus.cpu_rst, !ack);
    if (ack) begin
      repeat (20) @(negedge clk);
      check({tag, "_notx"}, txq.size(), 0);
    end else begin
      wait_tx({tag, "_r"}, 8'h15);
      check({tag, "_crst_hold"}, bus.cpu_rst, 1);
    end
  endtask

  initial begin
    string digits;
    bit    ack;
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[i] = c;
    end
    mem_hold     = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    digits = "123456789";
    pay.delete();
    for (int i = 0; i < digits.len(); i++) pay.push_back(digits[i]);
    run_upload("std", 32'hCBF4_3926, 1'b0);
    run_release("std", 1'b1);

    run_upload("badcrc", 32'h0000_0000, 1'b0);
    run_release("badcrc", 1'b0);

    // Oversize: NAK straight after the last size byte, no writes.
    wcount = 0;
    send_byte(8'h52, 6);
    send_byte(8'h01, 6);
    send_byte(8'h00, 6);
    send_byte(8'h08, 6);
    send_byte(8'h00, 0);
    check("oversize_lat", bus.tx_valid, 1);
    wait_tx("oversize", 8'h15);
    check("oversize_we", wcount, 0);

    send_byte(8'h52, 6);
    send_size(32'd0);
    wait_tx("zero", 8'h15);

    pay.delete();
    for (int i = 0; i < 8; i++) pay.push_back(8'($urandom));
    run_upload("overrun", ref_crc(), 1'b1);

    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 24);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
      c   = ref_crc();
      ack = ($urandom_range(0, 2) != 0);
      if (!ack) c = c ^ (32'd1 << $urandom_range(0, 31));
      run_upload($sformatf("rnd%0d", t), c, 1'b0);
      run_release($sformatf("rnd%0d", t), ack);
    end

`ifdef FW_TIMEOUT_EN
    send_byte(8'h52, 6);
    send_byte(8'h05, 6);
    send_byte(8'h00, 0);
    wait_tx("timeout", 8'h15);
    check("timeout_ok", bus.loaded_ok, 0);
`endif

    // Reset in the middle of the payload with a write held pending.
    send_byte(8'h52, 6);
    send_size(32'd8);
    send_byte(8'hA1, 6);
    send_byte(8'hA2, 6);
    mem_hold = 1'b1;
    send_byte(8'hA3, 6);
    send_byte(8'hA4, 2);
    check("mid_we", bus.mem_we, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    mem_hold = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_notx", txq.size(), 0);

    pay.delete();
    for (int i = 0; i < 5; i++) pay.push_back(8'($urandom));
    run_upload("after_rst", ref_crc(), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
